puf_ro_meter: RTL and testbench

- Parametrised successor to the single-CRO LED counter test: a multi-channel ring-oscillator frequency meter with challenge-pair comparison.
- Gates NUM_CH oscillators for a programmable window, counts each RO's edges safely in the clk domain, and reports two selected counts plus a 1-bit PUF response.
- Sits between the RO macro array and the response-collection/readout logic. Replaces the free-running 24-bit divider scheme with a start/busy/done handshake.

---
 rtl/puf_ro_meter.sv | 193 +++++++++++++++++++
 tb/tb_puf_ro_meter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/puf_ro_meter.sv
// puf_ro_meter: multi-channel ring-oscillator frequency meter.
// It gates NUM_CH ROs for a programmable window and counts each RO's
// prescaled edges in the clk domain. It then reports the counts of a
// challenge pair and a 1-bit PUF response (count_a > count_b).
`timescale 1ns/1ps
module puf_ro_meter #(
  parameter int NUM_CH     = 8,
  parameter int CNT_W      = 20,
  parameter int WIN_W      = 24,
  parameter int PRESC_LOG2 = 2,
  parameter int SETTLE_CYC = 16,
  parameter int SEL_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIN_W-1:0]  window,
  input  logic [SEL_W-1:0]  sel_a,
  input  logic [SEL_W-1:0]  sel_b,
  input  logic [NUM_CH-1:0] ro_in,
  output logic [NUM_CH-1:0] ro_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count_a,
  output logic [CNT_W-1:0]  count_b,
  output logic              response,
  output logic              tie,
  output logic              saturated
);

  localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                         state;
  logic [1:0]                     rst_pipe;
  logic                           rst_sync_n;
  logic [SETTLE_W-1:0]            settle_cnt;
  logic [WIN_W-1:0]               win_q;
  logic [WIN_W-1:0]               win_cnt;
  logic [1:0]                     drain_cnt;
  logic [SEL_W-1:0]               sel_a_q;
  logic [SEL_W-1:0]               sel_b_q;
  logic [NUM_CH-1:0]              ro_edge;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_all;
  logic                           clear_cnt;
  logic                           count_en;
  logic [CNT_W-1:0]               pick_a;
  logic [CNT_W-1:0]               pick_b;

  // Reset synchroniser: assert asynchronously, release on a clk edge.
  // NOTE: sequential state uses <= so all flops sample pre-edge values; = here would collapse the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_sync_n = rst_pipe[1];

  // The accept cycle clears the counters. They count only while MEASURE is active.
  assign clear_cnt = (state == S_IDLE) && start;
  assign count_en  = (state == S_MEASURE);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PRESC_LOG2-1:0] presc;
    logic                  presc_clr_n;
    logic [2:0]            sync;
    logic [CNT_W-1:0]      cnt;

    // The prescaler is held cleared whenever its RO is disabled.
    // Any stale phase therefore cannot leak into the next measurement.
    assign presc_clr_n = rst_sync_n & ro_en[i];

    // RO-domain divider, clocked by the oscillator itself.
    always_ff @(posedge ro_in[i] or negedge presc_clr_n) begin
      if (!presc_clr_n) presc <= '0;
      else              presc <= presc + 1'b1;
    end

    // Two-flop synchroniser of the divider MSB, plus an edge-history flop.
    always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) sync <= '0;
      else             sync <= {sync[1:0], presc[PRESC_LOG2-1]};
    end
    assign ro_edge[i] = sync[1] & ~sync[2];

    // Saturating edge counter.
    // NOTE: counter registers are reset explicitly; outputs must read 0 after reset.
    always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n)                             cnt <= '0;
      else if (clear_cnt)                          cnt <= '0;
      else if (count_en && ro_edge[i] && cnt != '1) cnt <= cnt + 1'b1;
    end
    assign cnt_all[i] = cnt;
  end

  // Channel mux. A select beyond the array reads as zero.
  function automatic logic [CNT_W-1:0] pick(input logic [SEL_W-1:0]             sel,
                                            input logic [NUM_CH-1:0][CNT_W-1:0] all);
    // NOTE: default before the loop so no path leaves the result unassigned (no latch).
    pick = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) pick = all[i];
    end
  endfunction

  assign pick_a = pick(sel_a_q, cnt_all);
  assign pick_b = pick(sel_b_q, cnt_all);

  // Measurement sequencer with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      win_q      <= '0;
      win_cnt    <= '0;
      drain_cnt  <= '0;
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      ro_en      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count_a    <= '0;
      count_b    <= '0;
      response   <= 1'b0;
      tie        <= 1'b0;
      saturated  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            win_q      <= window;
            sel_a_q    <= sel_a;
            sel_b_q    <= sel_b;
            settle_cnt <= '0;
            ro_en      <= '1;
            busy       <= 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_W'(SETTLE_CYC - 1)) begin
            if (win_q == '0) begin
              ro_en     <= '0;
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end else begin
              win_cnt <= win_q;
              state   <= S_MEASURE;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_MEASURE: begin
          if (win_cnt == WIN_W'(1)) begin
            ro_en     <= '0;
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else begin
            win_cnt <= win_cnt - 1'b1;
          end
        end
        S_DRAIN: begin
          // Three idle cycles flush the synchronisers before results are taken.
          if (drain_cnt == 2'd2) begin
            count_a   <= pick_a;
            count_b   <= pick_b;
            response  <= (pick_a > pick_b);
            tie       <= (pick_a == pick_b);
            saturated <= (&pick_a) | (&pick_b);
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_ro_meter.sv
// Bench for puf_ro_meter. It drives eight free-running RO models with periods
// (7+ch) ns against a 10 ns clk. It runs a full-width instance and a 6-bit
// saturating instance side by side, and scores each measurement against
// nominal counts derived from those periods.
`timescale 1ns/1ps
module tb_puf_ro_meter;
  localparam int NUM_CH     = 8;
  localparam int CNT_W      = 20;
  localparam int SAT_W      = 6;
  localparam int WIN_W      = 24;
  localparam int PRESC_LOG2 = 2;
  localparam int SETTLE_CYC = 16;
  localparam int SEL_W      = 4;
  localparam int SAT_MAX    = (1 << SAT_W) - 1;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b0;
  logic              start  = 1'b0;
  logic [WIN_W-1:0]  window = '0;
  logic [SEL_W-1:0]  sel_a  = '0;
  logic [SEL_W-1:0]  sel_b  = '0;
  wire  [NUM_CH-1:0] ro_in;

  logic [NUM_CH-1:0] ro_en, ro_en_s;
  logic              busy, done, response, tie, saturated;
  logic [CNT_W-1:0]  count_a, count_b;
  logic              busy_s, done_s, response_s, tie_s, saturated_s;
  logic [SAT_W-1:0]  count_a_s, count_b_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int sa;
    int sb;
    int w;
  } exp_t;
  exp_t sb_q[$];

  puf_ro_meter #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .PRESC_LOG2(PRESC_LOG2),
    .SETTLE_CYC(SETTLE_CYC), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .window(window), .sel_a(sel_a), .sel_b(sel_b),
    .ro_in(ro_in), .ro_en(ro_en), .busy(busy), .done(done), .count_a(count_a),
    .count_b(count_b), .response(response), .tie(tie), .saturated(saturated)
  );

  puf_ro_meter #(
    .NUM_CH(NUM_CH), .CNT_W(SAT_W), .WIN_W(WIN_W), .PRESC_LOG2(PRESC_LOG2),
    .SETTLE_CYC(SETTLE_CYC), .SEL_W(SEL_W)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .window(window), .sel_a(sel_a), .sel_b(sel_b),
    .ro_in(ro_in), .ro_en(ro_en_s), .busy(busy_s), .done(done_s), .count_a(count_a_s),
    .count_b(count_b_s), .response(response_s), .tie(tie_s), .saturated(saturated_s)
  );

  always #5 clk = ~clk;

  // RO models: channel g toggles every (7+g)/2 ns while enabled.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ro
    logic r = 1'b0;
    initial forever begin
      #((7.0 + g) / 2.0);
      r = ro_en[g] ? ~r : 1'b0;
    end
    assign ro_in[g] = r;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Nominal MSB edges in a window of w clk cycles for channel sel.
  function automatic int nominal(input int sel, input int w);
    if (sel >= NUM_CH) return 0;
    return (w * 10) / ((1 << PRESC_LOG2) * (7 + sel));
  endfunction

  task automatic run_meas(input int sa, input int sb, input int w,
                          input bit mid_start, input bit chg_win);
    exp_t e;
    int n, na, nb, ta, tb, ea, eb, extra;
    bit busy_ok, hold_ok;
    logic [CNT_W-1:0] prev_a;
    e.sa = sa; e.sb = sb; e.w = w;
    sb_q.push_back(e);
    prev_a = count_a;
    @(negedge clk);
    start = 1'b1; window = WIN_W'(w); sel_a = SEL_W'(sa); sel_b = SEL_W'(sb);
    @(posedge clk); #1;
    check("busy_on_accept", busy, 1);
    @(negedge clk);
    start = 1'b0;
    if (chg_win) begin
      window = WIN_W'(5); sel_a = SEL_W'(sb); sel_b = SEL_W'(sa);
    end
    n = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!done && n < SETTLE_CYC + w + 50) begin
      @(posedge clk); n++; #1;
      if (!done && !busy) busy_ok = 1'b0;
      if (!done && count_a !== prev_a) hold_ok = 1'b0;
      if (mid_start) start = (n == SETTLE_CYC + w / 2);
    end
    start = 1'b0;
    check("busy_continuous", busy_ok, 1);
    check("outputs_hold_while_busy", hold_ok, 1);
    check("done_seen", done, 1);
    check("done_latency", n, SETTLE_CYC + w + 3);
    check("sat_done", done_s, 1);
    if (sb_q.size() == 0) begin
      check("scoreboard_underflow", 1, 0);
    end else begin
      e  = sb_q.pop_front();
      na = nominal(e.sa, e.w);
      nb = nominal(e.sb, e.w);
      ta = (na == 0) ? 0 : 1;
      tb = (nb == 0) ? 0 : 1;
      check($sformatf("count_a=%0d nominal=%0d", count_a, na),
            (int'(count_a) >= na - ta) && (int'(count_a) <= na + ta), 1);
      check($sformatf("count_b=%0d nominal=%0d", count_b, nb),
            (int'(count_b) >= nb - tb) && (int'(count_b) <= nb + tb), 1);
      check("response", response, na > nb);
      check("tie", tie, na == nb);
      check("saturated", saturated, 0);
      ea = (na > SAT_MAX) ? SAT_MAX : na;
      eb = (nb > SAT_MAX) ? SAT_MAX : nb;
      check("sat_count_a", count_a_s, ea);
      check("sat_count_b", count_b_s, eb);
      check("sat_response", response_s, ea > eb);
      check("sat_tie", tie_s, ea == eb);
      check("sat_saturated", saturated_s, (ea == SAT_MAX) || (eb == SAT_MAX));
    end
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_released", busy, 0);
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("no_extra_done", extra, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int extra;
    #22;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ro_en", ro_en, 0);
    check("reset_count_a", count_a, 0);
    check("reset_response", response, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);

    run_meas(0, 1, 280, 1'b0, 1'b0);   // frequency pair
    run_meas(1, 0, 280, 1'b0, 1'b0);   // swapped selects
    run_meas(3, 3, 280, 1'b0, 1'b0);   // same channel
    run_meas(9, 2, 280, 1'b0, 1'b0);   // out-of-range select
    run_meas(0, 1, 0,   1'b0, 1'b0);   // empty window
    run_meas(0, 2, 1000, 1'b0, 1'b0);  // saturation in the narrow instance
    run_meas(0, 1, 280, 1'b1, 1'b0);   // start pulse during MEASURE
    run_meas(1, 2, 280, 1'b0, 1'b1);   // inputs changed after accept

    // Reset in the middle of MEASURE aborts the run.
    @(negedge clk);
    start = 1'b1; window = WIN_W'(280); sel_a = SEL_W'(0); sel_b = SEL_W'(1);
    @(negedge clk);
    start = 1'b0;
    repeat (SETTLE_CYC + 100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ro_en", ro_en, 0);
    check("abort_busy", busy, 0);
    check("abort_count_a", count_a, 0);
    check("abort_count_b", count_b, 0);
    check("abort_response", response, 0);
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("abort_no_done", extra, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    run_meas(0, 1, 280, 1'b0, 1'b0);   // fresh run after abort

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
